// File: rtl/fftframe_sink.sv
// Purpose: capture bit-reversed FFT frames into a ping-pong RAM and replay each frame as a valid/ready stream.
// Latency: first sample is presented 3 cycles after the write that completes a frame; gapless within a frame.
// Backpressure: i_ready stalls replay only; frames arriving with both banks full are dropped whole and counted.
module fftframe_sink #(
    parameter int DW      = 44,
    parameter int LGWIDTH = 11,
    parameter int CNTW    = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ce,
    input  logic               i_sync,
    input  logic [DW-1:0]      i_result,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DW-1:0]      o_data,
    output logic [LGWIDTH-1:0] o_index,
    output logic               o_last,
    output logic               o_overflow,
    output logic [CNTW-1:0]    o_dropped
);

    localparam int                 N        = 1 << LGWIDTH;
    localparam logic [LGWIDTH-1:0] LAST_BIN = '1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wstate_t;

    // Frame buffer: bank select is the top address bit
    logic [DW-1:0]      r_mem [0:2*N-1];
    logic [DW-1:0]      r_rdata;

    // Write side state
    wstate_t            r_state;
    wstate_t            w_state_nxt;
    logic [LGWIDTH-1:0] r_wptr;
    logic [LGWIDTH-1:0] w_wptr_nxt;
    logic [LGWIDTH-1:0] w_waddr_lo;
    logic               r_wbank;
    logic [1:0]         r_full;
    logic               w_we;
    logic               w_set_full;
    logic               w_drop;
    logic [LGWIDTH:0]   w_waddr;

    // Read side state: stage A is the RAM output, stage B is the output register
    logic               r_rbank;
    logic [LGWIDTH-1:0] r_rptr;
    logic               r_rd_done;
    logic               r_a_vld;
    logic [LGWIDTH-1:0] r_a_idx;
    logic               w_b_adv;
    logic               w_a_take;
    logic               w_re;
    logic               w_hs_last;
    logic [LGWIDTH:0]   w_raddr;

    assign w_waddr = {r_wbank, w_waddr_lo};
    assign w_raddr = {r_rbank, r_rptr};

    // Write FSM next-state: only moves on i_ce; sync decisions use the registered full flags
    always_comb begin
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_waddr_lo  = r_wptr;
        w_we        = 1'b0;
        w_set_full  = 1'b0;
        w_drop      = 1'b0;
        if (i_ce) begin
            case (r_state)
                HUNT, DROP: begin
                    if (i_sync) begin
                        if (!r_full[r_wbank]) begin
                            w_we        = 1'b1;
                            w_waddr_lo  = '0;
                            w_wptr_nxt  = LGWIDTH'(1);
                            w_state_nxt = WRITE;
                        end else begin
                            w_drop      = 1'b1;
                            w_state_nxt = DROP;
                        end
                    end
                end
                WRITE: begin
                    if (i_sync && (r_wptr != '0)) begin
                        // Misaligned frame start: restart the same bank from bin 0
                        w_we       = 1'b1;
                        w_waddr_lo = '0;
                        w_wptr_nxt = LGWIDTH'(1);
                    end else begin
                        w_we       = 1'b1;
                        w_waddr_lo = r_wptr;
                        w_wptr_nxt = r_wptr + LGWIDTH'(1);
                        if (r_wptr == LAST_BIN) begin
                            w_set_full  = 1'b1;
                            w_state_nxt = HUNT;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // Write FSM state register, bank pointer and drop accounting
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= HUNT;
            r_wptr     <= '0;
            r_wbank    <= 1'b0;
            o_overflow <= 1'b0;
            o_dropped  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wptr     <= w_wptr_nxt;
            o_overflow <= w_drop;
            if (w_set_full) begin
                r_wbank <= ~r_wbank;
            end
            if (w_drop && (o_dropped != '1)) begin
                o_dropped <= o_dropped + CNTW'(1);
            end
        end
    end

    // Bank-full flags: writer sets on completing a frame, reader clears on the last handshake
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_hs_last && (r_rbank == b[0])) begin
                    r_full[b] <= 1'b0;
                end else if (w_set_full && (r_wbank == b[0])) begin
                    r_full[b] <= 1'b1;
                end
            end
        end
    end

    // Frame RAM: one write port, one registered read port held when not reading
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= i_result;
        end
        if (w_re) begin
            r_rdata <= r_mem[w_raddr];
        end
    end

    assign w_b_adv   = !o_valid || i_ready;
    assign w_a_take  = r_a_vld && w_b_adv;
    assign w_re      = r_full[r_rbank] && !r_rd_done && (!r_a_vld || w_a_take);
    assign w_hs_last = o_valid && i_ready && o_last;

    // Read pipeline: issue RAM reads ahead of the output register so stalls never lose a sample
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rbank   <= 1'b0;
            r_rptr    <= '0;
            r_rd_done <= 1'b0;
            r_a_vld   <= 1'b0;
            r_a_idx   <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_index   <= '0;
            o_last    <= 1'b0;
        end else begin
            if (w_re) begin
                r_a_idx <= r_rptr;
                r_rptr  <= r_rptr + LGWIDTH'(1);
                if (r_rptr == LAST_BIN) begin
                    r_rd_done <= 1'b1;
                end
            end
            if (w_re) begin
                r_a_vld <= 1'b1;
            end else if (w_a_take) begin
                r_a_vld <= 1'b0;
            end
            if (w_b_adv) begin
                o_valid <= r_a_vld;
                if (r_a_vld) begin
                    o_data  <= r_rdata;
                    o_index <= r_a_idx;
                    o_last  <= (r_a_idx == LAST_BIN);
                end
            end
            if (w_hs_last) begin
                r_rbank   <= ~r_rbank;
                r_rd_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fftframe_sink.sv
// Purpose: scoreboard bench for fftframe_sink at N=16; stimulus pushes expected bins, a monitor pops on handshake.
// Latency: not applicable (bench).
// Backpressure: i_ready driven directly or randomised per cycle by the stimulus.
module tb_fftframe_sink;

    localparam int DW   = 44;
    localparam int LGW  = 4;
    localparam int N    = 16;
    localparam int CNTW = 16;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_ce;
    logic            i_sync;
    logic [DW-1:0]   i_result;
    logic            o_valid;
    logic            i_ready;
    logic [DW-1:0]   o_data;
    logic [LGW-1:0]  o_index;
    logic            o_last;
    logic            o_overflow;
    logic [CNTW-1:0] o_dropped;

    int total = 0;
    int bad   = 0;
    int ovf_cnt = 0;
    bit rnd_ready = 1'b0;
    logic [DW+LGW-1:0] sb[$];

    always #5 i_clk = ~i_clk;

    fftframe_sink #(.DW(DW), .LGWIDTH(LGW), .CNTW(CNTW)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_sync     (i_sync),
        .i_result   (i_result),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_index    (o_index),
        .o_last     (o_last),
        .o_overflow (o_overflow),
        .o_dropped  (o_dropped)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compare every handshake against the scoreboard, and stall stability
    logic           held = 1'b0;
    logic [DW-1:0]  h_data;
    logic [LGW-1:0] h_idx;
    always @(negedge i_clk) begin
        logic [DW+LGW-1:0] e;
        if (i_reset) begin
            held = 1'b0;
        end else begin
            if (o_overflow) ovf_cnt++;
            if (held) begin
                check("stall_valid", 64'(o_valid), 64'(1));
                check("stall_data", 64'(o_data), 64'(h_data));
                check("stall_index", 64'(o_index), 64'(h_idx));
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = sb.pop_front();
                    check("data", 64'(o_data), 64'(e[DW+LGW-1:LGW]));
                    check("index", 64'(o_index), 64'(e[LGW-1:0]));
                    check("last", 64'(o_last), 64'(e[LGW-1:0] == LGW'(N-1)));
                end
            end
            held   = o_valid && !i_ready;
            h_data = o_data;
            h_idx  = o_index;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
    endtask

    // Drive n samples base+k; sync on the first one if sync0; push to scoreboard if expected
    task automatic send(input int base, input int n, input bit sync0, input bit push, input bit gaps);
        for (int k = 0; k < n; k++) begin
            i_ce     = 1'b1;
            i_sync   = sync0 && (k == 0);
            i_result = DW'(base + k);
            if (push) sb.push_back({DW'(base + k), LGW'(k)});
            tick();
            i_ce   = 1'b0;
            i_sync = 1'b0;
            if (gaps) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while ((sb.size() != 0 || o_valid) && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) fail_now({name, "_timeout"});
    endtask

    initial begin
        i_reset  = 1'b1;
        i_ce     = 1'b0;
        i_sync   = 1'b0;
        i_result = '0;
        i_ready  = 1'b1;
        repeat (3) tick();
        @(negedge i_clk);
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_overflow", 64'(o_overflow), 64'(0));
        check("rst_dropped", 64'(o_dropped), 64'(0));
        check("rst_data", 64'(o_data), 64'(0));
        check("rst_index", 64'(o_index), 64'(0));
        check("rst_last", 64'(o_last), 64'(0));
        i_reset = 1'b0;
        tick();

        // Samples before the first sync must never appear
        send('hAA, 5, 1'b0, 1'b0, 1'b0);
        // One frame, data = bin number, consumer always ready
        send(0, N, 1'b1, 1'b1, 1'b0);
        drain("t1", 200);
        check("t1_dropped", 64'(o_dropped), 64'(0));

        // Three back-to-back frames with the consumer stalled: third is dropped
        ovf_cnt = 0;
        i_ready = 1'b0;
        send('h100, N, 1'b1, 1'b1, 1'b0);
        send('h200, N, 1'b1, 1'b1, 1'b0);
        send('h300, N, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("t2_ovf_pulses", 64'(ovf_cnt), 64'(1));
        check("t2_dropped", 64'(o_dropped), 64'(1));
        i_ready = 1'b1;
        drain("t2", 300);

        // Resync at sample 9: partial frame discarded, new frame starts at bin 0
        send('h500, 9, 1'b1, 1'b0, 1'b0);
        send('h600, N, 1'b1, 1'b1, 1'b0);
        drain("t3", 200);

        // Random backpressure and random input gaps
        rnd_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            int c = 0;
            while (sb.size() > N && c < 1000) begin
                tick();
                c++;
            end
            if (c >= 1000) fail_now("t4_space_timeout");
            send('h800 + 16 * f, N, 1'b1, 1'b1, 1'b1);
        end
        drain("t4", 2000);
        rnd_ready = 1'b0;
        i_ready   = 1'b1;
        tick();

        // Reset in the middle of readout
        begin
            int c = 0;
            bit seen = 1'b0;
            send('h900, N, 1'b1, 1'b1, 1'b0);
            while (!seen && c < 200) begin
                @(negedge i_clk);
                if (o_valid && o_index == LGW'(5)) seen = 1'b1;
                c++;
            end
            if (!seen) fail_now("t6_index5_timeout");
            tick();
            i_reset = 1'b1;
            i_ready = 1'b0;
            sb.delete();
            tick();
            @(negedge i_clk);
            check("t6_valid_after_reset", 64'(o_valid), 64'(0));
            check("t6_dropped_after_reset", 64'(o_dropped), 64'(0));
            i_reset = 1'b0;
            i_ready = 1'b1;
            tick();
            send('hA00, N, 1'b1, 1'b1, 1'b0);
            drain("t6", 200);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
